// File: rtl/hilo_pkg.sv
// Shared types and funct codes for the HI/LO accumulator unit.
// The MADD-family codes are only decoded when HILO_MADD_EN is defined.
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // SPECIAL funct space (MULOp = 0)
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // SPECIAL2 funct space (MULOp = 1)
  localparam logic [5:0] F_MADD  = 6'h00;
  localparam logic [5:0] F_MADDU = 6'h01;
  localparam logic [5:0] F_MSUB  = 6'h04;
  localparam logic [5:0] F_MSUBU = 6'h05;

  function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
    return (isSigned && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_div.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// operands held as magnitudes with the result signs restored in DONE.
module hilo_div
  import hilo_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        Clk,
  input  logic        RST,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        divZero_o,
  output logic        overflow_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      dvsr_q, dvsr_d;
  logic             qNeg_q, qNeg_d;
  logic             rNeg_q, rNeg_d;
  logic             divZero_q, divZero_d;
  logic             ovf_q, ovf_d;

  logic [32:0]      shifted;
  logic [33:0]      trial;

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      qNeg_q    <= 1'b0;
      rNeg_q    <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      qNeg_q    <= qNeg_d;
      rNeg_q    <= rNeg_d;
      divZero_q <= divZero_d;
      ovf_q     <= ovf_d;
    end
  end

  // quot_q doubles as the dividend shift register: its MSB feeds the remainder
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    qNeg_d    = qNeg_q;
    rNeg_d    = rNeg_q;
    divZero_d = divZero_q;
    ovf_d     = ovf_q;
    shifted   = {rem_q, quot_q[31]};
    trial     = {1'b0, shifted} - {2'b00, dvsr_q};

    case (state_q)
      IDLE: begin
        if (start_i) begin
          qNeg_d    = signed_i & (dividend_i[31] ^ divisor_i[31]);
          rNeg_d    = signed_i & dividend_i[31];
          ovf_d     = signed_i && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
          divZero_d = (divisor_i == 32'd0);
          quot_d    = absVal(dividend_i, signed_i);
          dvsr_d    = absVal(divisor_i, signed_i);
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = (divisor_i == 32'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (!trial[33]) begin
          rem_d  = trial[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = shifted[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o      = (state_q == BUSY);
    done_o      = (state_q == DONE);
    quotient_o  = qNeg_q ? (~quot_q + 32'd1) : quot_q;
    remainder_o = rNeg_q ? (~rem_q + 32'd1) : rem_q;
    divZero_o   = divZero_q;
    overflow_o  = ovf_q;
  end

endmodule

// File: rtl/hilo_acc.sv
// HI/LO accumulator: MF/MT, MULT capture and divider result write-back.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled with HILO_MADD_EN.
module hilo_acc
  import hilo_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        Clk,
  input  logic        RST,
  input  logic        En,
  input  logic        MULSelB,
  input  logic        MULOp,
  input  logic [5:0]  Func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [63:0] MULout,
  output logic [31:0] ACCout,
  output logic        ACCO,
  output logic        ACCZ,
  output logic        ACCN,
  output logic        ACCC,
  output logic        Stall
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        divStart;
  logic        divSigned;
  logic        divBusy;
  logic        divDone;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divZero;
  logic        divOvf;
  logic [31:0] doneVal;

`ifdef HILO_MADD_EN
  logic [63:0] accCur;
  logic [64:0] maddRes;
  logic        maddHit;
  logic        maddSub;
  logic        maddUns;
`endif

  assign divSigned = (Func == F_DIV);

  hilo_div #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .Clk        (Clk),
    .RST        (RST),
    .start_i    (divStart),
    .signed_i   (divSigned),
    .dividend_i (A),
    .divisor_i  (B),
    .busy_o     (divBusy),
    .done_o     (divDone),
    .quotient_o (quotient),
    .remainder_o(remainder),
    .divZero_o  (divZero),
    .overflow_o (divOvf)
  );

  always_ff @(posedge Clk) begin
    if (RST) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // A divide by zero still passes through DONE but leaves HI/LO untouched
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    ACCout   = '0;
    ACCO     = 1'b0;
    ACCZ     = 1'b0;
    ACCN     = 1'b0;
    ACCC     = 1'b0;
    Stall    = 1'b0;
    divStart = 1'b0;
    doneVal  = divZero ? lo_q : quotient;
`ifdef HILO_MADD_EN
    accCur  = {hi_q, lo_q};
    maddSub = (Func == F_MSUB) || (Func == F_MSUBU);
    maddUns = (Func == F_MADDU) || (Func == F_MSUBU);
    maddHit = (Func == F_MADD) || (Func == F_MADDU) || maddSub;
    maddRes = maddSub ? ({1'b0, accCur} - {1'b0, MULout})
                      : ({1'b0, accCur} + {1'b0, MULout});
`endif

    if (divDone) begin
      if (!divZero) begin
        hi_d = remainder;
        lo_d = quotient;
      end
      ACCout = doneVal;
      ACCZ   = (doneVal == 32'd0);
      ACCN   = doneVal[31];
      ACCO   = divOvf | divZero;
    end else if (divBusy) begin
      Stall = 1'b1;
    end else if (En) begin
      if (!MULOp) begin
        case (Func)
          F_MFHI: begin
            ACCout = hi_q;
            ACCZ   = (hi_q == 32'd0);
            ACCN   = hi_q[31];
          end
          F_MFLO: begin
            ACCout = lo_q;
            ACCZ   = (lo_q == 32'd0);
            ACCN   = lo_q[31];
          end
          F_MTHI, F_MTLO: begin
            if (!MULSelB) begin
              if (Func == F_MTHI) hi_d = A;
              else                lo_d = A;
              ACCout = A;
              ACCZ   = (A == 32'd0);
              ACCN   = A[31];
            end
          end
          F_MULT, F_MULTU: begin
            if (MULSelB) begin
              hi_d   = MULout[63:32];
              lo_d   = MULout[31:0];
              ACCout = MULout[31:0];
              ACCZ   = (MULout == 64'd0);
              ACCN   = MULout[63];
              ACCO   = (MULout[63:32] != 32'd0);
              ACCC   = (MULout[63:32] != 32'd0);
            end
          end
          F_DIV, F_DIVU: begin
            divStart = 1'b1;
            Stall    = 1'b1;
          end
          default: begin
          end
        endcase
      end else begin
`ifdef HILO_MADD_EN
        if (maddHit) begin
          hi_d   = maddRes[63:32];
          lo_d   = maddRes[31:0];
          ACCout = maddRes[31:0];
          ACCZ   = (maddRes[63:0] == 64'd0);
          ACCN   = maddRes[63];
          if (maddUns) begin
            ACCC = maddRes[64];
          end else if (maddSub) begin
            ACCO = (accCur[63] != MULout[63]) && (maddRes[63] != accCur[63]);
          end else begin
            ACCO = (accCur[63] == MULout[63]) && (maddRes[63] != accCur[63]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_hilo_acc.sv
// Self-checking bench for hilo_acc: vector table for single-cycle ops,
// scoreboard-tracked divide sequences, reset abort and MADD boundary.
module tb_hilo_acc;
  import hilo_pkg::*;

  typedef struct packed {
    logic [31:0] out;
    logic        o;
    logic        z;
    logic        n;
    logic        c;
    logic        stall;
  } exp_t;

  typedef struct {
    logic        en;
    logic        sel;
    logic        op;
    logic [5:0]  func;
    logic [31:0] a;
    logic [63:0] mul;
    exp_t        exp;
  } vec_t;

  logic        Clk;
  logic        RST;
  logic        En;
  logic        MULSelB;
  logic        MULOp;
  logic [5:0]  Func;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] MULout;
  logic [31:0] ACCout;
  logic        ACCO;
  logic        ACCZ;
  logic        ACCN;
  logic        ACCC;
  logic        Stall;

  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];
  vec_t vecs[$];

  hilo_acc #(.DIV_CYCLES(32)) dut (
    .Clk    (Clk),
    .RST    (RST),
    .En     (En),
    .MULSelB(MULSelB),
    .MULOp  (MULOp),
    .Func   (Func),
    .A      (A),
    .B      (B),
    .MULout (MULout),
    .ACCout (ACCout),
    .ACCO   (ACCO),
    .ACCZ   (ACCZ),
    .ACCN   (ACCN),
    .ACCC   (ACCC),
    .Stall  (Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t ex(input logic [31:0] out, input logic o, input logic z,
                              input logic n, input logic c, input logic stall);
    exp_t e;
    e.out = out; e.o = o; e.z = z; e.n = n; e.c = c; e.stall = stall;
    return e;
  endfunction

  function automatic vec_t mv(input logic en, input logic sel, input logic op,
                              input logic [5:0] f, input logic [31:0] a,
                              input logic [63:0] m, input exp_t e);
    vec_t v;
    v.en = en; v.sel = sel; v.op = op; v.func = f; v.a = a; v.mul = m; v.exp = e;
    return v;
  endfunction

  task automatic applyStimulus(input logic en, input logic sel, input logic op,
                               input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] m);
    En = en; MULSelB = sel; MULOp = op; Func = f; A = a; B = b; MULout = m;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t got;
    got = ex(ACCout, ACCO, ACCZ, ACCN, ACCC, Stall);
    total++;
    if (got !== e) begin
      bad++;
      $display("[TB] FAIL %s: got out=%h o=%b z=%b n=%b c=%b stall=%b, want out=%h o=%b z=%b n=%b c=%b stall=%b",
               name, got.out, got.o, got.z, got.n, got.c, got.stall,
               e.out, e.o, e.z, e.n, e.c, e.stall);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic singleOp(input string name, input logic en, input logic sel, input logic op,
                          input logic [5:0] f, input logic [31:0] a, input logic [63:0] m,
                          input exp_t e);
    @(negedge Clk);
    applyStimulus(en, sel, op, f, a, 32'd0, m);
    expQ.push_back(e);
    #1;
    checkOutput(name, expQ.pop_front());
  endtask

  task automatic runDiv(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input exp_t doneExp, input int wantStall);
    int cnt;
    int guard;
    @(negedge Clk);
    applyStimulus(1'b1, 1'b0, 1'b0, f, a, b, 64'd0);
    expQ.push_back(doneExp);
    #1;
    cnt = (Stall === 1'b1) ? 1 : 0;
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 32'd0, 32'd0, 64'd0);
    #1;
    guard = 0;
    while (Stall === 1'b1 && guard < 200) begin
      cnt++;
      guard++;
      @(negedge Clk);
      #1;
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout: got stall still high, want stall low", name);
    end
    checkCount({name, " stall cycles"}, cnt, wantStall);
    checkOutput({name, " done"}, expQ.pop_front());
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 32'd0, 32'd0, 64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    RST = 1'b0;
    #1;
    checkOutput("reset idle", ex(32'd0, 0, 0, 0, 0, 0));

    vecs.push_back(mv(1, 0, 0, F_MFLO,  32'd0,         64'd0,                 ex(32'd0,         0, 1, 0, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFHI,  32'd0,         64'd0,                 ex(32'd0,         0, 1, 0, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MTHI,  32'hDEADBEEF,  64'd0,                 ex(32'hDEADBEEF,  0, 0, 1, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFHI,  32'd0,         64'd0,                 ex(32'hDEADBEEF,  0, 0, 1, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MTLO,  32'h12345678,  64'd0,                 ex(32'h12345678,  0, 0, 0, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFLO,  32'd0,         64'd0,                 ex(32'h12345678,  0, 0, 0, 0, 0)));
    vecs.push_back(mv(0, 0, 0, F_MFLO,  32'd0,         64'd0,                 ex(32'd0,         0, 0, 0, 0, 0)));
    vecs.push_back(mv(1, 1, 0, F_MULT,  32'd0,         64'h00000001_00000000, ex(32'd0,         1, 0, 0, 1, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFHI,  32'd0,         64'd0,                 ex(32'd1,         0, 0, 0, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFLO,  32'd0,         64'd0,                 ex(32'd0,         0, 1, 0, 0, 0)));
    vecs.push_back(mv(1, 1, 0, F_MULTU, 32'd0,         64'h80000000_00000005, ex(32'd5,         1, 0, 1, 1, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFHI,  32'd0,         64'd0,                 ex(32'h80000000,  0, 0, 1, 0, 0)));
    vecs.push_back(mv(1, 1, 0, F_MTHI,  32'h0000ABCD,  64'd0,                 ex(32'd0,         0, 0, 0, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFHI,  32'd0,         64'd0,                 ex(32'h80000000,  0, 0, 1, 0, 0)));
    vecs.push_back(mv(1, 0, 0, 6'h3F,   32'h00000001,  64'd0,                 ex(32'd0,         0, 0, 0, 0, 0)));
`ifdef HILO_MADD_EN
    vecs.push_back(mv(1, 1, 1, F_MADD,  32'd0,         64'd1,                 ex(32'd6,         0, 0, 1, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFLO,  32'd0,         64'd0,                 ex(32'd6,         0, 0, 0, 0, 0)));
`else
    vecs.push_back(mv(1, 1, 1, F_MADD,  32'd0,         64'd1,                 ex(32'd0,         0, 0, 0, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFLO,  32'd0,         64'd0,                 ex(32'd5,         0, 0, 0, 0, 0)));
`endif
    vecs.push_back(mv(1, 1, 0, F_MULT,  32'd0,         64'd0,                 ex(32'd0,         0, 1, 0, 0, 0)));
    vecs.push_back(mv(1, 0, 0, F_MFHI,  32'd0,         64'd0,                 ex(32'd0,         0, 1, 0, 0, 0)));

    for (int i = 0; i < vecs.size(); i++) begin
      singleOp($sformatf("vec%0d", i), vecs[i].en, vecs[i].sel, vecs[i].op,
               vecs[i].func, vecs[i].a, vecs[i].mul, vecs[i].exp);
    end

    // DIV -7 / 2 -> quotient -3, remainder -1
    runDiv("div -7/2", F_DIV, 32'hFFFFFFF9, 32'd2, ex(32'hFFFFFFFD, 0, 0, 1, 0, 0), 33);
    singleOp("div mfhi", 1, 0, 0, F_MFHI, 32'd0, 64'd0, ex(32'hFFFFFFFF, 0, 0, 1, 0, 0));
    singleOp("div mflo", 1, 0, 0, F_MFLO, 32'd0, 64'd0, ex(32'hFFFFFFFD, 0, 0, 1, 0, 0));

    // DIVU by zero: one stall cycle, HI/LO untouched
    runDiv("divu 7/0", F_DIVU, 32'd7, 32'd0, ex(32'hFFFFFFFD, 1, 0, 1, 0, 0), 1);
    singleOp("dz mfhi", 1, 0, 0, F_MFHI, 32'd0, 64'd0, ex(32'hFFFFFFFF, 0, 0, 1, 0, 0));
    singleOp("dz mflo", 1, 0, 0, F_MFLO, 32'd0, 64'd0, ex(32'hFFFFFFFD, 0, 0, 1, 0, 0));

    // Most-negative over -1
    runDiv("div min/-1", F_DIV, 32'h80000000, 32'hFFFFFFFF, ex(32'h80000000, 1, 0, 1, 0, 0), 33);
    singleOp("ovf mfhi", 1, 0, 0, F_MFHI, 32'd0, 64'd0, ex(32'd0, 0, 1, 0, 0, 0));
    singleOp("ovf mflo", 1, 0, 0, F_MFLO, 32'd0, 64'd0, ex(32'h80000000, 0, 0, 1, 0, 0));

    // DIVU 1000/7 -> 142 r 6
    runDiv("divu 1000/7", F_DIVU, 32'd1000, 32'd7, ex(32'd142, 0, 0, 0, 0, 0), 33);
    singleOp("divu mfhi", 1, 0, 0, F_MFHI, 32'd0, 64'd0, ex(32'd6, 0, 0, 0, 0, 0));

    // Reset aborts a divide at BUSY cycle 10
    @(negedge Clk);
    applyStimulus(1'b1, 1'b0, 1'b0, F_DIV, 32'd100, 32'd3, 64'd0);
    #1;
    checkOutput("abort issue", ex(32'd0, 0, 0, 0, 0, 1));
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 32'd0, 32'd0, 64'd0);
      #1;
    end
    checkOutput("abort busy10", ex(32'd0, 0, 0, 0, 0, 1));
    RST = 1'b1;
    @(negedge Clk);
    #1;
    checkOutput("abort after rst", ex(32'd0, 0, 0, 0, 0, 0));
    RST = 1'b0;
    singleOp("abort mfhi", 1, 0, 0, F_MFHI, 32'd0, 64'd0, ex(32'd0, 0, 1, 0, 0, 0));
    singleOp("abort mflo", 1, 0, 0, F_MFLO, 32'd0, 64'd0, ex(32'd0, 0, 1, 0, 0, 0));

    // MADDU wrap of an all-ones accumulator
    singleOp("madd mthi", 1, 0, 0, F_MTHI, 32'hFFFFFFFF, 64'd0, ex(32'hFFFFFFFF, 0, 0, 1, 0, 0));
    singleOp("madd mtlo", 1, 0, 0, F_MTLO, 32'hFFFFFFFF, 64'd0, ex(32'hFFFFFFFF, 0, 0, 1, 0, 0));
`ifdef HILO_MADD_EN
    singleOp("maddu wrap", 1, 1, 1, F_MADDU, 32'd0, 64'd1, ex(32'd0, 0, 1, 0, 1, 0));
    singleOp("maddu mfhi", 1, 0, 0, F_MFHI, 32'd0, 64'd0, ex(32'd0, 0, 1, 0, 0, 0));
    singleOp("maddu mflo", 1, 0, 0, F_MFLO, 32'd0, 64'd0, ex(32'd0, 0, 1, 0, 0, 0));
`else
    singleOp("maddu off", 1, 1, 1, F_MADDU, 32'd0, 64'd1, ex(32'd0, 0, 0, 0, 0, 0));
    singleOp("maddu mfhi", 1, 0, 0, F_MFHI, 32'd0, 64'd0, ex(32'hFFFFFFFF, 0, 0, 1, 0, 0));
    singleOp("maddu mflo", 1, 0, 0, F_MFLO, 32'd0, 64'd0, ex(32'hFFFFFFFF, 0, 0, 1, 0, 0));
`endif

    @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_acc.md
Name: hilo_acc

Overview:
- HI/LO accumulator unit for the execute stage.
- Receives the accumulator enable, operand-select, funct and 64-bit multiplier product from execute control.
- Holds the architectural HI/LO pair and executes MULT/MULTU result capture, MTHI/MTLO and MFHI/MFLO.
- Executes DIV/DIVU as an iterative 32-cycle divide, stalling the pipeline while it runs.
- Returns a 32-bit read value plus O/Z/N/C flags to execute control, combinationally in the same cycle.

Parameters:
- DIV_CYCLES, 32, number of restoring-division iterations; must equal the operand width.

Ports:
- Clk  input  1  pipeline clock
- RST  input  1  synchronous active-high reset
- En  input  1  accumulator enable from execute control
- MULSelB  input  1  1 = write source is MULout; 0 = write source is A (MTHI/MTLO)
- MULOp  input  1  1 = SPECIAL2 funct space; 0 = SPECIAL funct space
- Func  input  6  instruction funct field
- A  input  32  rs operand (dividend; MTHI/MTLO data)
- B  input  32  rt operand (divisor)
- MULout  input  64  multiplier product
- ACCout  output  32  read/result value
- ACCO  output  1  overflow flag
- ACCZ  output  1  zero flag
- ACCN  output  1  negative flag
- ACCC  output  1  carry flag
- Stall  output  1  holds the pipeline during a divide

Behaviour:
- One clock Clk; reset RST is synchronous, active-high.
- Reset values: HI=0, LO=0, state=IDLE, divider registers 0. Outputs are combinational and therefore 0 after reset, except ACCZ=1 for an MFHI/MFLO read of zero.
- Operations are decoded only when En=1 and state=IDLE. En=0 means no state change, ACCout=0 and all flags 0.
- Funct codes in SPECIAL space (MULOp=0): MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- MFHI/MFLO: ACCout = HI/LO; Z = (value==0); N = value[31]; O = 0; C = 0; no register write.
- MTHI/MTLO (requires MULSelB=0): at the clock edge HI/LO <= A. ACCout = A; flags follow the same rule as MF.
- MULT/MULTU (MULSelB=1): at the clock edge {HI,LO} <= MULout. ACCout = MULout[31:0]; Z = (MULout==0) over 64 bits; N = MULout[63]; C = O = (MULout[63:32]!=0).
- Any other funct with En=1: no-op, ACCout=0, all flags 0.
- Divide FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on DIV/DIVU. Latch operand magnitudes and signs (DIVU treats both operands as unsigned).
  - Stall asserts combinationally in that same cycle.
  - BUSY: one quotient bit per cycle; counter runs 0..DIV_CYCLES-1.
  - BUSY -> DONE after the last iteration.
  - DONE: Stall=0. At the clock edge LO <= quotient and HI <= remainder, then -> IDLE.
  - Total latency: the issue cycle plus DIV_CYCLES plus 1 (Stall high for 33 cycles).
- Signed division: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Boundary: 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0, with O=1 reported in DONE.
- Divide by zero: IDLE -> DONE directly (Stall high for 1 cycle). HI/LO unchanged; O=1 in DONE.
- In DONE: ACCout = new LO; Z = (quotient==0); N = quotient[31].
- While state is not IDLE, En/Func are ignored; the pipeline is frozen by Stall.
- RST asserted mid-divide aborts: state=IDLE, HI=LO=0, Stall=0 in the next cycle.

Optional Feature:
- Macro HILO_MADD_EN.
- When defined, MULOp=1 with En=1 decodes MADD 0x00, MADDU 0x01, MSUB 0x04, MSUBU 0x05.
  - Result is {HI,LO} <= {HI,LO} ± MULout.
  - ACCout = new LO; Z and N are taken over the 64-bit result.
  - MADDU/MSUBU: C = carry/borrow out of bit 63.
  - MADD/MSUB: O = signed 64-bit overflow.
- When undefined, MULOp=1 is a no-op: ACCout=0, flags 0, HI/LO unchanged.

Decomposition:
- Package hilo_pkg:
  - state enum {IDLE,BUSY,DONE}
  - funct localparams for the eight SPECIAL codes
  - the four MADD-family codes
- Sub-module hilo_div: iterative restoring divider with start/busy/done handshake and sign fix-up. hilo_acc owns HI/LO, decode and flags.

Test Plan:
- Reset, then MFLO -> ACCout=0, ACCZ=1; MTHI A=0xDEADBEEF then MFHI -> ACCout=0xDEADBEEF, ACCN=1.
- MULT with MULout=0x00000001_00000000 -> ACCout=0, ACCZ=0, ACCO=ACCC=1; subsequent MFHI=1, MFLO=0.
- DIV A=-7, B=2 -> Stall high for exactly 33 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU A=7, B=0 -> Stall high for 1 cycle; HI/LO unchanged; ACCO=1 in DONE.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; RST at BUSY cycle 10 -> Stall=0, HI=LO=0 next cycle.
- HILO_MADD_EN: HI:LO=0xFFFFFFFF_FFFFFFFF, MADDU MULout=1 -> HI=LO=0, ACCC=1, ACCZ=1; macro off -> HI/LO unchanged.
